// File: rtl/uart_tx_serializer.sv
// UART TX serializer: loads a parallel word, computes its parity and shifts it out LSB-first.
// Optional one-entry hold buffer is compiled in when TX_HOLD_BUF_EN is defined.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  busy,
  input  logic                  ser_en,
  input  logic                  PAR_TYP,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  par_bit,
  output logic                  data_pending,
  output logic                  drop_err
);

  localparam int CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] word, input logic odd);
    calc_parity = (^word) ^ odd;
  endfunction

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  par_q, par_d;
  logic                  drop_q, drop_d;
  logic                  load_s;
  logic                  drop_s;
  logic [DATA_WIDTH-1:0] load_word_s;

`ifdef TX_HOLD_BUF_EN
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;

  // A held word has priority over a fresh strobe; the fresh word then refills the hold.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load_s      = 1'b0;
    drop_s      = 1'b0;
    load_word_s = P_DATA;
    if (!busy && hold_full_q) begin
      load_s      = 1'b1;
      load_word_s = hold_q;
      if (Data_Valid) begin
        hold_d      = P_DATA;
        hold_full_d = 1'b1;
      end else begin
        hold_full_d = 1'b0;
      end
    end else if (Data_Valid && !busy) begin
      load_s = 1'b1;
    end else if (Data_Valid) begin
      if (!hold_full_q) begin
        hold_d      = P_DATA;
        hold_full_d = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // Hold buffer registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_q      <= {DATA_WIDTH{1'b0}};
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign data_pending = hold_full_q;
`else
  // Without a hold buffer a strobe during a frame is simply lost.
  always_comb begin
    load_s      = Data_Valid && !busy;
    drop_s      = Data_Valid && busy;
    load_word_s = P_DATA;
  end

  assign data_pending = 1'b0;
`endif

  // Load beats shift; a stalled ser_en freezes both the word and the bit counter.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    drop_d  = drop_q | drop_s;
    if (load_s) begin
      shift_d = load_word_s;
      cnt_d   = CNT_ZERO;
      par_d   = calc_parity(load_word_s, PAR_TYP);
    end else if (ser_en) begin
      shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
      cnt_d   = (cnt_q == LAST_CNT) ? CNT_ZERO : (cnt_q + CNT_ONE);
    end else begin
      shift_d = shift_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_q <= {DATA_WIDTH{1'b0}};
      cnt_q   <= CNT_ZERO;
      par_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      drop_q  <= drop_d;
    end
  end

  assign ser_data = shift_q[0];
  assign ser_done = ser_en && (cnt_q == LAST_CNT);
  assign par_bit  = par_q;
  assign drop_err = drop_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized bench for uart_tx_serializer against a word/shift-count reference model.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] p_data;
  logic       dv, busy, ser_en, par_typ;
  logic       ser_data, ser_done, par_bit, data_pending, drop_err;

  int n_checks = 0;
  int n_errors = 0;

  // Model: the loaded word, how many enabled shifts since load, parity, sticky drop, hold queue.
  int         m_word;
  int         m_shifts;
  bit         m_par;
  bit         m_drop;
  logic [7:0] m_hold[$];

  uart_tx_serializer #(.DATA_WIDTH(8)) dut (
    .CLK(clk), .RST(rst_n), .P_DATA(p_data), .Data_Valid(dv), .busy(busy),
    .ser_en(ser_en), .PAR_TYP(par_typ), .ser_data(ser_data), .ser_done(ser_done),
    .par_bit(par_bit), .data_pending(data_pending), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_word = 0; m_shifts = 0; m_par = 1'b0; m_drop = 1'b0;
    m_hold.delete();
  endtask

  task automatic m_load(input logic [7:0] w, input logic pt);
    m_word   = int'(w);
    m_shifts = 0;
    m_par    = bit'(($countones(w) % 2) != 0) ^ pt;
  endtask

  task automatic check_outputs(input string tag);
    logic exp_data;
    exp_data = (m_shifts < 8) ? logic'((m_word >> m_shifts) & 1) : 1'b0;
    check_eq({tag, "_ser_data"}, 32'(ser_data), 32'(exp_data));
    check_eq({tag, "_ser_done"}, 32'(ser_done), 32'(ser_en && ((m_shifts % 8) == 7)));
    check_eq({tag, "_par_bit"},  32'(par_bit),  32'(m_par));
    check_eq({tag, "_drop_err"}, 32'(drop_err), 32'(m_drop));
    check_eq({tag, "_pending"},  32'(data_pending), 32'(m_hold.size() != 0));
  endtask

  // One clock: drive on falling edge, check outputs, then apply the spec rules at the rising edge.
  task automatic step(input string tag, input logic v, input logic [7:0] d, input logic b,
                      input logic en, input logic pt);
    bit loaded;
    @(negedge clk);
    dv = v; p_data = d; busy = b; ser_en = en; par_typ = pt;
    #1;
    check_outputs(tag);
    @(posedge clk);
    loaded = 1'b0;
`ifdef TX_HOLD_BUF_EN
    if (!b && m_hold.size() != 0) begin
      m_load(m_hold.pop_front(), pt);
      loaded = 1'b1;
      if (v) m_hold.push_back(d);
    end else if (v && !b) begin
      m_load(d, pt);
      loaded = 1'b1;
    end else if (v) begin
      if (m_hold.size() == 0) m_hold.push_back(d);
      else m_drop = 1'b1;
    end
`else
    if (v && !b) begin
      m_load(d, pt);
      loaded = 1'b1;
    end else if (v) begin
      m_drop = 1'b1;
    end
`endif
    if (!loaded && en) m_shifts++;
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    dv = 1'b0; busy = 1'b0; ser_en = 1'b1; par_typ = 1'b0; p_data = 8'h00;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_eq({tag, "_ser_data"}, 32'(ser_data), 32'd0);
    check_eq({tag, "_ser_done"}, 32'(ser_done), 32'd0);
    check_eq({tag, "_par_bit"},  32'(par_bit),  32'd0);
    check_eq({tag, "_drop_err"}, 32'(drop_err), 32'd0);
    check_eq({tag, "_pending"},  32'(data_pending), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; dv = 1'b0; busy = 1'b0; ser_en = 1'b0; par_typ = 1'b0; p_data = 8'h00;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ser_data", 32'(ser_data), 32'd0);
    check_eq("rst_par_bit",  32'(par_bit),  32'd0);
    check_eq("rst_drop_err", 32'(drop_err), 32'd0);
    check_eq("rst_pending",  32'(data_pending), 32'd0);
    rst_n = 1'b1;

    // 0xA5 even parity, 8 enabled cycles, plus a 2-cycle stall after bit 3
    step("a5_load", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    check_eq("a5_par_const", 32'(par_bit), 32'd0);
    for (int i = 0; i < 4; i++) step("a5_shift", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step("a5_stall", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step("a5_drop", 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("a5_shift", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    step("a5_tail", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef TX_HOLD_BUF_EN
    check_eq("hold_pending_set", 32'(data_pending), 32'd1);
    step("hold_release", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_eq("hold_pending_clr", 32'(data_pending), 32'd0);
    step("hold_fill", 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    step("hold_overflow", 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    check_eq("hold_drop_const", 32'(drop_err), 32'd1);
    step("hold_drain", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`else
    check_eq("drop_const", 32'(drop_err), 32'd1);
    step("drop_sticky", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_eq("drop_sticky_const", 32'(drop_err), 32'd1);
`endif

    // Parity type sampled only at load
    step("p07_even", 1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    check_eq("p07_even_const", 32'(par_bit), 32'd1);
    step("p07_odd", 1'b1, 8'h07, 1'b0, 1'b0, 1'b1);
    check_eq("p07_odd_const", 32'(par_bit), 32'd0);
    for (int i = 0; i < 3; i++) step("p07_toggle", 1'b0, 8'h00, 1'b1, 1'b0, 1'(i % 2 == 0));
    check_eq("p07_hold_const", 32'(par_bit), 32'd0);

    // Reset mid-shift at bit 3 with drop_err set
    step("rs_load", 1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    step("rs_busy1", 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
    step("rs_busy2", 1'b1, 8'h6B, 1'b1, 1'b1, 1'b0);
    step("rs_shift", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    do_reset("rs_mid");
    for (int i = 0; i < 8; i++) step("rs_after", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset("rnd_rst");
      step("rnd", 1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
